led_matrix_scan_ctrl: RTL

Parametrised successor to the fixed 16x16 column-scan LED driver. It drives a ROWS x COLS LED matrix one column at a time from a flat frame bitmap, using a clock-enable tick instead of derived clocks. New features: a double-buffered frame with tear-free swap at frame end, per-column blanking against ghosting, PWM brightness, row flip, and an enable. It sits between the game/render logic that produces the frame bitmap and the matrix pins.

---
 rtl/led_scan_pkg.sv | 18 +
 rtl/scan_tick_gen.sv | 24 ++
 rtl/led_matrix_scan_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/led_scan_pkg.sv
// Shared types and sizing helpers for the LED matrix column-scan driver.
package led_scan_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      LIT   = 2'd2
   } scan_state_e;

   function automatic int col_width(input int cols);
      return (cols > 1) ? $clog2(cols) : 1;
   endfunction

   function automatic int slot_len(input int blank_ticks, input int bright_w);
      return blank_ticks + (1 << bright_w) - 1;
   endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Clock-enable prescaler: one-cycle tick every TICK_DIV cycles while enabled.
module scan_tick_gen #(
   parameter int TICK_DIV = 3125
)(
   input  logic clk_sys,
   input  logic rst,
   input  logic enable,
   output logic tick
);

   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign tick  = enable && (cnt_q == CNT_W'(TICK_DIV - 1));
   assign cnt_d = (!enable || tick) ? '0 : cnt_q + CNT_W'(1);

   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/led_matrix_scan_ctrl.sv
// Column-scan LED matrix driver: double-buffered frame, per-column blanking,
// PWM brightness and row flip, paced by a clock-enable scan tick.
module led_matrix_scan_ctrl
   import led_scan_pkg::*;
#(
   parameter int ROWS        = 16,
   parameter int COLS        = 16,
   parameter int TICK_DIV    = 3125,
   parameter int BRIGHT_W    = 4,
   parameter int BLANK_TICKS = 1
)(
   input  logic                     clk_sys,
   input  logic                     rst,
   input  logic                     enable,
   input  logic [ROWS*COLS-1:0]     frame_in,
   input  logic                     frame_load,
   output logic                     frame_ack,
   input  logic [BRIGHT_W-1:0]      brightness,
   input  logic                     flip_v,
   output logic [ROWS-1:0]          data_col,
   output logic [$clog2(COLS)-1:0]  curr_col,
   output logic                     frame_start
);

   localparam int COL_W  = col_width(COLS);
   localparam int SLOT   = slot_len(BLANK_TICKS, BRIGHT_W);
   localparam int SLOT_W = (SLOT > 1) ? $clog2(SLOT) : 1;

   scan_state_e         state_q;
   logic [SLOT_W-1:0]   slot_q;
   logic [COL_W-1:0]    col_q;
   logic                start_q;
   logic [ROWS*COLS-1:0] active_q;
   logic [ROWS*COLS-1:0] pending_q;
   logic                pending_valid_q;
   logic [ROWS-1:0]     data_col_q;
   logic [ROWS-1:0]     data_col_d;
   logic [COL_W-1:0]    curr_col_q;
   logic [COL_W-1:0]    curr_col_d;
   logic                frame_start_q;
   logic                frame_ack_q;

   logic                run;
   logic                tick;
   logic                swap;
   logic                lit_on;
   logic [SLOT_W-1:0]   lit_idx;
   logic [COLS-1:0]     row_bits;
   logic [ROWS-1:0]     col_bits;
   logic [ROWS-1:0]     mapped;

   // The prescaler is held clear in IDLE so every slot, including the first, is full length.
   assign run = enable && (state_q != IDLE);

   scan_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .clk_sys (clk_sys),
      .rst     (rst),
      .enable  (run),
      .tick    (tick)
   );

   always_comb begin
      row_bits = '0;
      col_bits = '0;
      mapped   = '0;
      for (int r = 0; r < ROWS; r++) begin
         row_bits    = active_q[r*COLS +: COLS];
         col_bits[r] = row_bits[col_q];
      end
      for (int r = 0; r < ROWS; r++)
         mapped[r] = flip_v ? col_bits[ROWS-1-r] : col_bits[r];
   end

   assign lit_idx    = slot_q - SLOT_W'(BLANK_TICKS);
   assign lit_on     = 32'(lit_idx) < 32'(brightness);
   assign data_col_d = (enable && (state_q == LIT) && lit_on) ? mapped : '0;
   assign curr_col_d = enable ? col_q : '0;

   // Frame boundaries (start_q) trail the FSM by one cycle, lining the swap up with curr_col.
   assign swap = pending_valid_q && ((state_q == IDLE) || start_q);

   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         slot_q        <= '0;
         col_q         <= '0;
         start_q       <= 1'b0;
         data_col_q    <= '0;
         curr_col_q    <= '0;
         frame_start_q <= 1'b0;
      end else begin
         data_col_q    <= data_col_d;
         curr_col_q    <= curr_col_d;
         frame_start_q <= enable && start_q;
         start_q       <= 1'b0;
         if (!enable) begin
            state_q <= IDLE;
            slot_q  <= '0;
            col_q   <= '0;
         end else begin
            case (state_q)
               IDLE: begin
                  state_q <= BLANK;
                  slot_q  <= '0;
                  col_q   <= '0;
                  start_q <= 1'b1;
               end
               default: begin
                  if (tick) begin
                     if (slot_q == SLOT_W'(SLOT - 1)) begin
                        slot_q  <= '0;
                        state_q <= BLANK;
                        if (col_q == COL_W'(COLS - 1)) begin
                           col_q   <= '0;
                           start_q <= 1'b1;
                        end else begin
                           col_q <= col_q + COL_W'(1);
                        end
                     end else begin
                        slot_q  <= slot_q + SLOT_W'(1);
                        state_q <= (32'(slot_q) + 32'd1 >= 32'(BLANK_TICKS)) ? LIT : BLANK;
                     end
                  end
               end
            endcase
         end
      end
   end

   // A load coinciding with a swap lands in pending while active takes the older frame.
   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         active_q        <= '0;
         pending_q       <= '0;
         pending_valid_q <= 1'b0;
         frame_ack_q     <= 1'b0;
      end else begin
         frame_ack_q <= swap;
         if (swap)
            active_q <= pending_q;
         if (frame_load) begin
            pending_q       <= frame_in;
            pending_valid_q <= 1'b1;
         end else if (swap) begin
            pending_valid_q <= 1'b0;
         end
      end
   end

   assign data_col    = data_col_q;
   assign curr_col    = curr_col_q;
   assign frame_start = frame_start_q;
   assign frame_ack   = frame_ack_q;

endmodule
